// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-channel push-button synchronizer, debouncer and press/release/hold strobe generator
//
// Purpose:
//   Turns N raw, bouncing, asynchronous button contacts into clean per-channel
//   signals for downstream control FSMs. Every channel is an independent copy
//   of the same logic: a two-flop synchronizer, a debounce counter that must
//   see DB_CYCLES consecutive disagreeing samples before the debounced level
//   flips, and a saturating hold counter that raises a single long-press
//   strobe once the level has been high for LONG_CYCLES cycles.
//
// Parameters:
//   N            number of button channels
//   DB_CYCLES    consecutive stable cycles needed to accept a change (>= 2)
//   LONG_CYCLES  cycles of debounced high before btnHold fires (> DB_CYCLES)
//
// Ports:
//   clk100Mhz   in   1  single clock
//   rst         in   1  asynchronous active-high reset (release is already
//                       synchronous to clk100Mhz at board level)
//   btnRaw      in   N  raw active-high button contacts, asynchronous
//   btnLevel    out  N  debounced level
//   btnPress    out  N  one-cycle strobe on each accepted 0->1 change
//   btnRelease  out  N  one-cycle strobe on each accepted 1->0 change
//   btnHold     out  N  one-cycle strobe after LONG_CYCLES of debounced high,
//                       at most once per press

module btn_debounce #(
  parameter int N           = 3,
  parameter int DB_CYCLES   = 1000,
  parameter int LONG_CYCLES = 50000
) (
  input  logic         clk100Mhz,
  input  logic         rst,
  input  logic [N-1:0] btnRaw,
  output logic [N-1:0] btnLevel,
  output logic [N-1:0] btnPress,
  output logic [N-1:0] btnRelease,
  output logic [N-1:0] btnHold
);

  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  // The state flop doubles as the debounced level register, so the encoding
  // is fixed: RELEASED must be 0 and PRESSED must be 1.
  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } state_t;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_ch
      logic              r_s1;
      logic              r_s2;
      logic [DB_W-1:0]   r_db_cnt;
      logic [DB_W-1:0]   w_db_cnt_nxt;
      logic [HOLD_W-1:0] r_hold_cnt;
      logic [HOLD_W-1:0] w_hold_cnt_nxt;
      state_t            r_state;
      state_t            w_state_nxt;
      logic              r_press;
      logic              r_release;
      logic              r_hold;
      logic              w_press_nxt;
      logic              w_release_nxt;
      logic              w_hold_nxt;
      logic              w_level;
      logic              w_differ;
      logic              w_accept;

      // Two-flop synchronizer; r_s2 is the only consumer-facing copy of the
      // raw input.
      always_ff @(posedge clk100Mhz or posedge rst) begin
        if (rst) begin
          r_s1 <= 1'b0;
          r_s2 <= 1'b0;
        end else begin
          r_s1 <= btnRaw[g];
          r_s2 <= r_s1;
        end
      end

      assign w_level  = (r_state == ST_PRESSED);
      assign w_differ = (r_s2 != w_level);
      // The DB_CYCLES-th consecutive disagreeing sample flips the level.
      assign w_accept = w_differ && (r_db_cnt == DB_LAST);

      // Debounce counter: any agreeing sample (a bounce back) restarts it.
      always_comb begin
        w_db_cnt_nxt = r_db_cnt;
        if (!w_differ || w_accept) begin
          w_db_cnt_nxt = '0;
        end else begin
          w_db_cnt_nxt = r_db_cnt + DB_ONE;
        end
      end

      // Hold counter: saturating at LONG_CYCLES is what limits btnHold to one
      // pulse per press, however long the button stays down.
      always_comb begin
        w_hold_cnt_nxt = r_hold_cnt;
        w_hold_nxt     = 1'b0;
        if (!w_level) begin
          w_hold_cnt_nxt = '0;
        end else if (r_hold_cnt != HOLD_MAX) begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_ONE;
          w_hold_nxt     = (r_hold_cnt == HOLD_LAST);
        end
      end

      // Level FSM: transitions only on debounce acceptance. In RELEASED an
      // acceptance implies r_s2 = 1, in PRESSED it implies r_s2 = 0.
      always_comb begin
        w_state_nxt   = r_state;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
          ST_RELEASED: begin
            if (w_accept) begin
              w_state_nxt = ST_PRESSED;
              w_press_nxt = 1'b1;
            end
          end
          ST_PRESSED: begin
            if (w_accept) begin
              w_state_nxt   = ST_RELEASED;
              w_release_nxt = 1'b1;
            end
          end
        endcase
      end

      always_ff @(posedge clk100Mhz or posedge rst) begin
        if (rst) begin
          r_state    <= ST_RELEASED;
          r_db_cnt   <= '0;
          r_hold_cnt <= '0;
          r_press    <= 1'b0;
          r_release  <= 1'b0;
          r_hold     <= 1'b0;
        end else begin
          r_state    <= w_state_nxt;
          r_db_cnt   <= w_db_cnt_nxt;
          r_hold_cnt <= w_hold_cnt_nxt;
          r_press    <= w_press_nxt;
          r_release  <= w_release_nxt;
          r_hold     <= w_hold_nxt;
        end
      end

      assign btnLevel[g]   = w_level;
      assign btnPress[g]   = r_press;
      assign btnRelease[g] = r_release;
      assign btnHold[g]    = r_hold;
    end
  endgenerate

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - scoreboard testbench for btn_debounce with a sliding-window reference model
module tb_btn_debounce;

  localparam int N    = 3;
  localparam int DB   = 4;
  localparam int LONG = 20;

  logic           clk100Mhz = 1'b0;
  logic           rst       = 1'b1;
  logic [N-1:0]   btnRaw    = '1;
  logic [N-1:0]   btnLevel;
  logic [N-1:0]   btnPress;
  logic [N-1:0]   btnRelease;
  logic [N-1:0]   btnHold;

  always #5 clk100Mhz = ~clk100Mhz;

  btn_debounce #(.N(N), .DB_CYCLES(DB), .LONG_CYCLES(LONG)) dut (
    .clk100Mhz (clk100Mhz),
    .rst       (rst),
    .btnRaw    (btnRaw),
    .btnLevel  (btnLevel),
    .btnPress  (btnPress),
    .btnRelease(btnRelease),
    .btnHold   (btnHold)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] hold;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad   = 0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: a level flips at edge t when the raw samples taken at
  // edges t-DB-1 .. t-2 all disagree with it (two sync stages of delay).
  // Hold fires LONG edges after the press edge if still pressed.
  logic [N-1:0] hq[$];
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_nlev;
  int           press_edge[N];
  int           cyc = 0;
  exp_t         m_e;
  bit           m_diff;

  always begin
    @(posedge clk100Mhz or posedge rst);
    if (rst) begin
      hq.delete();
      m_level = '0;
      exp_q.delete();
    end else begin
      cyc++;
      m_e.cyc   = cyc;
      m_e.press = '0;
      m_e.rel   = '0;
      m_e.hold  = '0;
      m_nlev    = m_level;
      for (int ch = 0; ch < N; ch++) begin
        if (m_level[ch] && (cyc - press_edge[ch] == LONG)) m_e.hold[ch] = 1'b1;
        if (hq.size() >= DB + 1) begin
          m_diff = 1'b1;
          for (int k = hq.size() - 1 - DB; k <= hq.size() - 2; k++)
            if (hq[k][ch] == m_level[ch]) m_diff = 1'b0;
          if (m_diff) begin
            m_nlev[ch] = ~m_level[ch];
            if (m_nlev[ch]) begin
              m_e.press[ch]  = 1'b1;
              press_edge[ch] = cyc;
            end else begin
              m_e.rel[ch] = 1'b1;
            end
          end
        end
      end
      m_level = m_nlev;
      hq.push_back(btnRaw);
      while (hq.size() > DB + 2) void'(hq.pop_front());
      if ((m_e.press | m_e.rel | m_e.hold) != '0) exp_q.push_back(m_e);
    end
  end

  // Monitor / scoreboard plus a few per-channel statistics for directed checks.
  exp_t me;
  int   n_press[N];
  int   n_rel[N];
  int   n_hold[N];
  int   last_press_cyc[N];
  int   last_rel_cyc[N];
  int   last_hold_cyc[N];
  bit   sim_seen = 1'b0;

  always begin
    @(negedge clk100Mhz);
    if (!rst) begin
      chk("level", int'(btnLevel), int'(m_level));
      chk("press_and_release_same_cycle", int'(btnPress & btnRelease), 0);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        me = exp_q.pop_front();
        chk("press", int'(btnPress), int'(me.press));
        chk("release", int'(btnRelease), int'(me.rel));
        chk("hold", int'(btnHold), int'(me.hold));
      end else begin
        chk("unexpected_strobe", int'({btnPress, btnRelease, btnHold}), 0);
      end
      for (int ch = 0; ch < N; ch++) begin
        if (btnPress[ch])   begin n_press[ch]++; last_press_cyc[ch] = cyc; end
        if (btnRelease[ch]) begin n_rel[ch]++;   last_rel_cyc[ch]   = cyc; end
        if (btnHold[ch])    begin n_hold[ch]++;  last_hold_cyc[ch]  = cyc; end
      end
      if (btnPress == '1) sim_seen = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk100Mhz);
  endtask

  task automatic clr_counts();
    for (int ch = 0; ch < N; ch++) begin
      n_press[ch] = 0;
      n_rel[ch]   = 0;
      n_hold[ch]  = 0;
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_level"}, int'(btnLevel), 0);
    chk({name, "_press"}, int'(btnPress), 0);
    chk({name, "_release"}, int'(btnRelease), 0);
    chk({name, "_hold"}, int'(btnHold), 0);
  endtask

  logic bp [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  int   c0;
  int   dur[N];

  initial begin
    // Reset held with all buttons pressed.
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk_outputs_zero("reset_hold");
    end
    btnRaw = '0;
    rst    = 1'b0;
    tick(6);

    // Clean press / release on channel 0.
    clr_counts();
    c0 = cyc;
    btnRaw = 3'b001;
    tick(10);
    chk("clean_press_latency", last_press_cyc[0] - c0, DB + 2);
    c0 = cyc;
    btnRaw = 3'b000;
    tick(10);
    chk("clean_release_latency", last_rel_cyc[0] - c0, DB + 2);
    chk("clean_press_count", n_press[0], 1);
    chk("clean_release_count", n_rel[0], 1);
    chk("clean_other_bits", n_press[1] + n_press[2] + n_rel[1] + n_rel[2], 0);

    // Bounce rejection on channel 1.
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      btnRaw[1] = bp[i];
      tick(1);
    end
    chk("bounce_no_strobe", n_press[1] + n_rel[1], 0);
    c0 = cyc;
    btnRaw[1] = 1'b1;
    tick(12);
    chk("bounce_press_count", n_press[1], 1);
    chk("bounce_press_latency", last_press_cyc[1] - c0, DB + 2);
    chk("bounce_no_release", n_rel[1], 0);
    btnRaw[1] = 1'b0;
    tick(10);

    // Long press on channel 2, then a press too short to hold.
    clr_counts();
    btnRaw[2] = 1'b1;
    tick(40);
    chk("long_press_count", n_press[2], 1);
    chk("long_hold_count", n_hold[2], 1);
    chk("long_hold_delay", last_hold_cyc[2] - last_press_cyc[2], LONG);
    btnRaw[2] = 1'b0;
    tick(10);
    clr_counts();
    btnRaw[2] = 1'b1;
    tick(15);
    btnRaw[2] = 1'b0;
    tick(10);
    chk("short_press_count", n_press[2], 1);
    chk("short_no_hold", n_hold[2], 0);

    // Simultaneous press on all channels.
    sim_seen = 1'b0;
    btnRaw = 3'b111;
    tick(10);
    chk("simultaneous_press", int'(sim_seen), 1);
    btnRaw = 3'b000;
    tick(10);

    // Asynchronous reset pulse between clock edges.
    btnRaw = 3'b001;
    tick(10);
    chk("pre_pulse_level", int'(btnLevel[0]), 1);
    #2 rst = 1'b1;
    #1 chk_outputs_zero("async_pulse");
    #1 rst = 1'b0;
    clr_counts();
    tick(10);
    chk("repress_after_pulse", n_press[0], 1);

    // Reset held for three cycles while still pressed.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_outputs_zero("reset_mid_press");
    end
    rst = 1'b0;
    c0 = cyc;
    clr_counts();
    tick(10);
    chk("repress_after_reset", n_press[0], 1);
    chk("repress_latency", last_press_cyc[0] - c0, DB + 2);
    btnRaw = 3'b000;
    tick(10);

    // Randomized contact activity, checked by the scoreboard.
    for (int ch = 0; ch < N; ch++) dur[ch] = $urandom_range(1, 30);
    repeat (1500) begin
      for (int ch = 0; ch < N; ch++) begin
        if (dur[ch] == 0) begin
          btnRaw[ch] = ~btnRaw[ch];
          dur[ch]    = $urandom_range(1, 40);
        end else begin
          dur[ch]--;
        end
      end
      tick(1);
    end
    btnRaw = 3'b000;
    tick(12);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
